fully_connected_array: RTL
==========================

Name: fully_connected_array

Overview:
- Parametrised successor to the single-MAC fully connected core.
- Computes NUM_CH output neurons in parallel over an IN_LENGTH-element input vector. One input node is broadcast per beat with NUM_CH weights.
- Bias is added once per vector, not once per beat.
- Sits between the feature buffer and the activation/output stage of the FC layer; a controller drives one vector per i_run.

Parameters:
- IN_DATA_WIDTH, 8, signed width of node, weight and bias.
- NUM_CH, 4, number of parallel output channels.
- IN_LENGTH, 16, beats per vector (≥1).
- ACC_WIDTH, 32, signed accumulator/result width per channel. Must be ≥ 2*IN_DATA_WIDTH+clog2(IN_LENGTH)+1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_run  in  1  start pulse; clears accumulators, latches i_bias.
- i_valid  in  1  input beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- i_node  in  IN_DATA_WIDTH  signed input activation.
- i_wegt  in  NUM_CH*IN_DATA_WIDTH  signed weights, channel c at [c*W +: W].
- i_bias  in  NUM_CH*IN_DATA_WIDTH  signed biases, sampled only with i_run.
- o_valid  out  1  one-cycle pulse, result valid.
- o_result  out  NUM_CH*ACC_WIDTH  signed results, channel c at [c*ACC_WIDTH +: ACC_WIDTH].
- o_idle  out  1  high in IDLE.

Behaviour:
- Reset: state IDLE, o_ready=0, o_valid=0, o_result=0, o_idle=1. All accumulators, pipeline valids and the beat counter are cleared.
- FSM states:
  - IDLE: o_ready=0; i_valid is ignored. On i_run go to RUN.
  - RUN: o_ready=1. The beat counter increments on each accepted beat. When the IN_LENGTH-th beat is accepted, go to DRAIN.
  - DRAIN: o_ready=0. Wait until the product and accumulate stages are empty, then go to DONE.
  - DONE: result register = acc + sign-extended bias; o_valid=1 for this one cycle; next state IDLE.
- i_run in any state (including RUN/DRAIN/DONE) aborts the current vector:
  - clears accumulators, pipeline valids and the counter;
  - relatches bias and enters RUN next cycle;
  - no o_valid is emitted for the aborted vector.
  - i_run has priority over i_valid in the same cycle; that beat is dropped.
- Pipeline:
  - Stage 1 registers the NUM_CH products (2*W, signed).
  - Stage 2 sign-extends each product to ACC_WIDTH and accumulates.
- Latency: if the last beat is sampled at edge T, o_valid is high in the cycle after edge T+3 (3 cycles after the beat).
- Bubbles: i_valid may drop at any time in RUN; nothing advances on idle cycles.
- o_result holds its value until the next DONE or reset.
- Arithmetic: two's complement, wrap on ACC_WIDTH overflow, no saturation.
- Reset during any state returns the block to the reset values above on the next edge.

Optional Feature:
- Macro: FC_ARRAY_RELU_EN.
- Defined: in DONE, any channel whose acc+bias is negative is written as 0.
- Undefined: the raw signed sum is output.
- Latency is identical in both builds.

Decomposition:
- Shared package fc_pkg holds:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - the ACC_WIDTH minimum-width check function;
  - lane slice helper constants.
- One natural sub-module, fc_mac_lane: one channel's product register, accumulator and bias add. It is instantiated NUM_CH times via generate.
- The top keeps the FSM, counter and handshake.

Test Plan (NUM_CH=2, W=8, IN_LENGTH=4, ACC_WIDTH=32):
- Basic vector: i_run with bias {−3,5}; nodes 1,2,3,4 back-to-back; weights ch0=1, ch1=−2 → single o_valid 3 cycles after beat 4; ch0=15, ch1=−23.
- Bubbles and idle: same vector with i_valid gaps of 0–3 cycles, plus i_valid pulses while IDLE → identical results, exactly one o_valid, and the IDLE beats are ignored.
- Extremes: node=−128, weights=−128 on both channels, bias 0 → 65536 per channel, no wrap.
- Abort: i_run after beat 2, then a fresh vector of nodes 2,2,2,2 with weights 3, bias 0 → only one o_valid, result 24 on both channels.
- Reset mid-RUN: assert reset after beat 3 → next cycle o_ready=0, o_idle=1, o_result=0, no o_valid.
- FC_ARRAY_RELU_EN defined: basic vector → ch0=15, ch1=0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected array: FSM state encoding,
// accumulator width sanity check and lane slicing helper.
// No logic; imported by fully_connected_array and fc_mac_lane.
package fc_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Accumulator must hold IN_LENGTH full-scale products plus a sign bit.
  function automatic bit acc_width_ok(input int acc_w, input int data_w, input int len);
    return acc_w >= (2 * data_w + $clog2(len) + 1);
  endfunction

  // Low bit of lane 'lane' in a bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output channel: product register, accumulator, latched bias and result register.
// Latency: product 1 cycle, accumulate 1 cycle; result loaded on load_res.
// No backpressure; clr wins over all other controls. FC_ARRAY_RELU_EN clamps negative results to 0.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int W         = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 beat,
  input  logic                 acc_en,
  input  logic                 load_res,
  input  logic [W-1:0]         node,
  input  logic [W-1:0]         wegt,
  input  logic [W-1:0]         bias_in,
  output logic [ACC_WIDTH-1:0] result
);

  logic signed [2*W-1:0]       prod_d, prod_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [W-1:0]         bias_d, bias_q;
  logic signed [ACC_WIDTH-1:0] res_d, res_q;
  logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, sum;

  // Next-state for product, accumulator, bias and result registers
  always_comb begin
    prod_ext = {{(ACC_WIDTH-2*W){prod_q[2*W-1]}}, prod_q};
    bias_ext = {{(ACC_WIDTH-W){bias_q[W-1]}}, bias_q};
    sum      = acc_q + bias_ext;

    prod_d = prod_q;
    if (beat) prod_d = $signed(node) * $signed(wegt);

    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q + prod_ext;

    bias_d = bias_q;
    if (clr) bias_d = bias_in;

    res_d = res_q;
    if (load_res) begin
`ifdef FC_ARRAY_RELU_EN
      res_d = sum[ACC_WIDTH-1] ? '0 : sum;
`else
      res_d = sum;
`endif
    end
  end

  // Lane registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
      bias_q <= '0;
      res_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      bias_q <= bias_d;
      res_q  <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/fully_connected_array.sv
// NUM_CH parallel neurons over an IN_LENGTH vector; one broadcast node per beat, bias once per vector.
// Latency: o_valid pulses 3 cycles after the last accepted beat.
// o_ready only in RUN; i_run aborts/restarts at any time. Option FC_ARRAY_RELU_EN clamps negatives to 0.
module fully_connected_array
  import fc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_CH        = 4,
  parameter int IN_LENGTH     = 16,
  parameter int ACC_WIDTH     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_run,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [IN_DATA_WIDTH-1:0]      i_node,
  input  logic [NUM_CH*IN_DATA_WIDTH-1:0] i_wegt,
  input  logic [NUM_CH*IN_DATA_WIDTH-1:0] i_bias,
  output logic                          o_valid,
  output logic [NUM_CH*ACC_WIDTH-1:0]   o_result,
  output logic                          o_idle
);

  localparam int CNT_W = $clog2(IN_LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_LENGTH - 1);

  if (!acc_width_ok(ACC_WIDTH, IN_DATA_WIDTH, IN_LENGTH)) begin : g_bad_acc
    $error("fully_connected_array: ACC_WIDTH too narrow for IN_DATA_WIDTH/IN_LENGTH");
  end

  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             p_vld_d, p_vld_q;
  logic             a_vld_d, a_vld_q;
  logic             beat, load_res;

  // FSM, beat counter and pipeline valid tracking; i_run overrides everything
  always_comb begin
    beat    = (state_q == ST_RUN) && i_valid && !i_run;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_RUN:   if (beat && (cnt_q == LAST_BEAT)) state_d = ST_DRAIN;
      ST_DRAIN: if (!p_vld_q && !a_vld_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_run) state_d = ST_RUN;

    cnt_d = cnt_q;
    if (i_run)     cnt_d = '0;
    else if (beat) cnt_d = cnt_q + 1'b1;

    p_vld_d  = beat;
    a_vld_d  = p_vld_q && !i_run;
    // result is written on the edge that enters DONE, so it is visible while o_valid is high
    load_res = (state_d == ST_DONE);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_vld_q <= 1'b0;
      a_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_vld_q <= p_vld_d;
      a_vld_q <= a_vld_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fc_mac_lane #(
      .W         (IN_DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr      (i_run),
      .beat     (beat),
      .acc_en   (p_vld_q),
      .load_res (load_res),
      .node     (i_node),
      .wegt     (i_wegt[lane_lo(c, IN_DATA_WIDTH) +: IN_DATA_WIDTH]),
      .bias_in  (i_bias[lane_lo(c, IN_DATA_WIDTH) +: IN_DATA_WIDTH]),
      .result   (o_result[lane_lo(c, ACC_WIDTH) +: ACC_WIDTH])
    );
  end

  assign o_ready = (state_q == ST_RUN);
  assign o_valid = (state_q == ST_DONE);
  assign o_idle  = (state_q == ST_IDLE);

endmodule
